uart_tx_arbiter: RTL and testbench

Shares one UART transmit serializer (8N1, 115200 baud at 50 MHz) among NUM_REQ byte-stream requesters. Arbitration is round-robin and packet-locked: a granted requester keeps the transmitter until it hands over a byte flagged last. The block sits between the application-side byte sources and the uart_tx serializer, whose byte-level valid/ready port it drives.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default timing
// constants and the round-robin index helper.
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  // One bit time at 115200 baud, in ns.
  localparam int unsigned BPS_115200 = 8680;

  // Default system clock period, in ns (50 MHz).
  localparam int unsigned CLK_PERIOD_NS = 20;

  // Candidate index `step` positions after `base`, wrapping modulo `n`.
  function automatic int unsigned rr_index(input int unsigned base, input int unsigned step,
                                           input int unsigned n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1,
// wrapping. Returns the choice one-hot and as a binary index. All zeros when nothing
// is requesting.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int unsigned NumReq = 4,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] pick_o,
  output logic [IdxW-1:0]   idx_o
);

  logic        found;
  int unsigned cand;

  // Scan ptr+1 .. ptr+NumReq; the previous owner (ptr itself) is checked last.
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    cand   = 0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand = rr_index(32'(ptr_i), k, NumReq);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        pick_o[cand] = 1'b1;
        idx_o        = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART byte serializer among NUM_REQ
// requesters. The owner's valid/data/ready are passed straight through; ownership
// ends on a handshake of a byte flagged last.
// Optional stall eviction is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IdxW-1:0]    gidx_q;
  logic [IdxW-1:0]    ptr_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] pick;
  logic [IdxW-1:0]    pick_idx;
  logic               own;
  logic               own_valid;
  logic               hs;
  logic               hs_last;

  rr_pick #(
    .NumReq(NUM_REQ)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .pick_o(pick),
    .idx_o (pick_idx)
  );

  assign own       = (state_q == ST_OWN);
  assign own_valid = req_valid[gidx_q];
  assign hs        = own & own_valid & tx_ready;
  assign hs_last   = hs & req_last[gidx_q];

  // Owner pass-through; everything reads zero outside OWN.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    if (own) begin
      tx_valid  = own_valid;
      tx_data   = req_data[{gidx_q, 3'b000} +: 8];
      req_ready = grant_q & {NUM_REQ{tx_ready}};
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            timeout_q;
  logic            stall_expire;

  // This stall cycle is the TIMEOUT_CYCLES-th in a row.
  assign stall_expire = own & ~own_valid & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign timeout      = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant = grant_q;
  assign busy  = busy_q;

  // Arbitration FSM, rotation pointer and optional stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= IdxW'(NUM_REQ - 1);
      busy_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (|req_valid) begin
            state_q <= ST_OWN;
            grant_q <= pick;
            gidx_q  <= pick_idx;
            busy_q  <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        ST_OWN: begin
          if (hs_last) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= gidx_q;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (hs) begin
            cnt_q <= '0;
          end else if (stall_expire) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= gidx_q;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
          end else if (!own_valid) begin
            cnt_q <= cnt_q + CntW'(1);
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Requester byte streams come from a source
// queue; every scored byte is also pushed to an expected queue in the order the
// arbiter should send it, and a negedge monitor pops and compares on each transfer.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout;

  typedef struct packed {logic [1:0] r; logic [7:0] d; logic last;} beat_t;
  typedef struct packed {logic [1:0] r; logic [7:0] d;} exp_t;

  beat_t        src_q[$];
  exp_t         exp_q[$];
  exp_t         e_cur;
  int           checks   = 0;
  int           failures = 0;
  logic [N-1:0] hs_seen;
  int           drv_j;

  uart_tx_arbiter #(
    .NUM_REQ       (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .grant    (grant),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic int find_first(input int r);
    for (int k = 0; k < src_q.size(); k++) begin
      if (int'(src_q[k].r) == r) return k;
    end
    return -1;
  endfunction

  // Monitor: record handshakes and score every byte handed to the serializer.
  always @(negedge clk) begin
    hs_seen = rst ? '0 : (req_valid & req_ready);
    if (!rst && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got byte %02h grant %b, required no transfer",
                 tx_data, grant);
      end else begin
        e_cur = exp_q.pop_front();
        if (tx_data !== e_cur.d) begin
          failures++;
          $display("FAIL sb_data: got %02h, required %02h", tx_data, e_cur.d);
        end
        checks++;
        if (grant !== (4'b0001 << e_cur.r)) begin
          failures++;
          $display("FAIL sb_owner: got grant %b, required owner %0d", grant, e_cur.r);
        end
      end
    end
  end

  // Requester models: present the head byte of each stream, advance after a handshake.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      drv_j = find_first(i);
      if (hs_seen[i] && drv_j >= 0) begin
        src_q.delete(drv_j);
        drv_j = find_first(i);
      end
      if (drv_j >= 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_q[drv_j].d;
        req_last[i]        = src_q[drv_j].last;
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic last, input bit scored);
    src_q.push_back('{r: 2'(r), d: d, last: last});
    if (scored) exp_q.push_back('{r: 2'(r), d: d});
  endtask

  task automatic do_reset();
    tick();
    rst      = 1'b1;
    tx_ready = 1'b0;
    src_q.delete();
    exp_q.delete();
    tick();
    tick();
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drained: %0d bytes still expected, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tx_ready = 1'b1;
    push_byte(0, 8'h5A, 1'b1, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin
      failures++; $display("FAIL reset_grant: got %b, required 0000", grant);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++;
    if (timeout !== 1'b0) begin
      failures++; $display("FAIL reset_timeout: got %b, required 0", timeout);
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++; $display("FAIL reset_tx_valid: got %b, required 0", tx_valid);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_req_ready: got %b, required 0000", req_ready);
    end
    checks++;
    if (tx_data !== 8'h00) begin
      failures++; $display("FAIL reset_tx_data: got %02h, required 00", tx_data);
    end
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check_drained("reset");
  endtask

  task automatic test_single();
    int   tv;
    int   tg;
    int   h1;
    int   h2;
    logic busy_after;
    tv = -1; tg = -1; h1 = -1; h2 = -1; busy_after = 1'bx;
    do_reset();
    rst      = 1'b0;
    tx_ready = 1'b1;
    push_byte(2, 8'hA3, 1'b0, 1'b1);
    push_byte(2, 8'h5C, 1'b1, 1'b1);
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (tv < 0 && req_valid[2]) tv = n;
      if (tg < 0 && grant === 4'b0100) tg = n;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        if (h1 < 0) h1 = n;
        else if (h2 < 0) h2 = n;
      end
      if (h2 >= 0 && n == h2 + 1) busy_after = busy;
    end
    checks++;
    if (tg != tv + 1 || tv < 0) begin
      failures++; $display("FAIL single_grant_latency: grant at %0d, required %0d", tg, tv + 1);
    end
    checks++;
    if (h1 != tg) begin
      failures++; $display("FAIL single_first_byte: byte at %0d, required %0d", h1, tg);
    end
    checks++;
    if (h2 != h1 + 1) begin
      failures++; $display("FAIL single_back_to_back: second at %0d, required %0d", h2, h1 + 1);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      failures++; $display("FAIL single_busy_drop: got %b, required 0", busy_after);
    end
    check_drained("single");
  endtask

  task automatic test_contention();
    logic [3:0] exp_pat [12];
    int         seen;
    exp_pat = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0};
    seen = 0;
    do_reset();
    rst      = 1'b0;
    tx_ready = 1'b1;
    push_byte(0, 8'h10, 1'b0, 1'b1); push_byte(0, 8'h11, 1'b1, 1'b1);
    push_byte(1, 8'h20, 1'b0, 1'b1); push_byte(1, 8'h21, 1'b1, 1'b1);
    push_byte(3, 8'h30, 1'b0, 1'b1); push_byte(3, 8'h31, 1'b1, 1'b1);
    for (int n = 0; n < 6 && seen == 0; n++) begin
      @(negedge clk);
      if (req_valid != 4'b0000) seen = 1;
    end
    checks++;
    if (seen == 0) begin
      failures++; $display("FAIL contention_start: requests never appeared, required within 6");
    end
    for (int p = 0; p < 12; p++) begin
      if (p > 0) @(negedge clk);
      checks++;
      if (grant !== exp_pat[p]) begin
        failures++;
        $display("FAIL contention_grant[%0d]: got %b, required %b", p, grant, exp_pat[p]);
      end
    end
    check_drained("contention");
  endtask

  task automatic test_backpressure();
    int bad_other;
    int bad_rdy;
    int n_hs1;
    bad_other = 0; bad_rdy = 0; n_hs1 = 0;
    do_reset();
    rst = 1'b0;
    push_byte(1, 8'h41, 1'b0, 1'b1);
    push_byte(1, 8'h42, 1'b0, 1'b1);
    push_byte(1, 8'h43, 1'b0, 1'b1);
    push_byte(1, 8'h44, 1'b1, 1'b1);
    push_byte(3, 8'h77, 1'b1, 1'b1);
    for (int k = 0; k < 80; k++) begin
      tick();
      tx_ready = (k % 10 == 0);
      @(negedge clk);
      if (grant === 4'b0010 && (req_ready & 4'b1101) != 4'b0000) bad_other++;
      if (req_ready[1] && !tx_ready) bad_rdy++;
      if (req_valid[1] && req_ready[1]) n_hs1++;
    end
    checks++;
    if (bad_other != 0) begin
      failures++; $display("FAIL bp_other_ready: %0d bad cycles, required 0", bad_other);
    end
    checks++;
    if (bad_rdy != 0) begin
      failures++; $display("FAIL bp_ready_gating: %0d bad cycles, required 0", bad_rdy);
    end
    checks++;
    if (n_hs1 != 4) begin
      failures++; $display("FAIL bp_byte_count: got %0d transfers, required 4", n_hs1);
    end
    check_drained("bp");
  endtask

  task automatic test_reset_mid();
    int         n_hs;
    logic [3:0] first_g;
    n_hs = 0; first_g = 4'h0;
    do_reset();
    rst = 1'b0;
    push_byte(3, 8'hC1, 1'b0, 1'b1);
    push_byte(3, 8'hC2, 1'b0, 1'b1);
    push_byte(3, 8'hC3, 1'b0, 1'b0);
    push_byte(3, 8'hC4, 1'b0, 1'b0);
    push_byte(3, 8'hC5, 1'b1, 1'b0);
    for (int k = 0; k < 20 && n_hs < 2; k++) begin
      tick();
      tx_ready = (k % 2 == 0);
      @(negedge clk);
      if (req_valid[3] && req_ready[3]) n_hs++;
    end
    tick();
    tx_ready = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin
      failures++; $display("FAIL rstmid_grant: got %b, required 0000", grant);
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_tx_valid: got %b, required 0", tx_valid);
    end
    tick();
    src_q.delete();
    exp_q.delete();
    tx_ready = 1'b1;
    push_byte(0, 8'h01, 1'b1, 1'b1);
    push_byte(3, 8'h03, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10 && first_g == 4'h0; k++) begin
      @(negedge clk);
      first_g = grant;
    end
    checks++;
    if (first_g !== 4'b0001) begin
      failures++; $display("FAIL rstmid_first_grant: got %b, required 0001", first_g);
    end
    repeat (8) tick();
    check_drained("rstmid");
  endtask

  task automatic test_timeout();
    int         h;
    int         tp;
    int         pulses;
    bit         g2;
    logic [3:0] last_g;
    h = -1; tp = -1; pulses = 0; g2 = 1'b0; last_g = 4'h0;
    do_reset();
    rst      = 1'b0;
    tx_ready = 1'b1;
    push_byte(0, 8'h11, 1'b0, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
    push_byte(2, 8'h22, 1'b1, 1'b1);
`else
    push_byte(2, 8'h22, 1'b1, 1'b0);
`endif
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (h < 0 && req_valid[0] && req_ready[0]) h = n;
      if (timeout === 1'b1) begin
        pulses++;
        if (tp < 0) tp = n;
      end
      if (tp >= 0 && grant === 4'b0100) g2 = 1'b1;
      last_g = grant;
    end
`ifdef UART_ARB_TIMEOUT_EN
    checks++;
    if (pulses != 1) begin
      failures++; $display("FAIL to_pulse_count: got %0d, required 1", pulses);
    end
    checks++;
    if (tp != h + 1 + TO || h < 0) begin
      failures++; $display("FAIL to_pulse_cycle: got %0d, required %0d", tp, h + 1 + TO);
    end
    checks++;
    if (!g2) begin
      failures++; $display("FAIL to_next_grant: req 2 granted=%0b, required 1", g2);
    end
`else
    checks++;
    if (pulses != 0) begin
      failures++; $display("FAIL to_no_pulse: got %0d pulses, required 0", pulses);
    end
    checks++;
    if (last_g !== 4'b0001) begin
      failures++; $display("FAIL to_hold_grant: got %b, required 0001", last_g);
    end
`endif
    check_drained("to");
    do_reset();
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    tx_ready = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
